// File: rtl/shared_unit_arbiter.sv
// shared_unit_arbiter: lets NUM_REQ two-operand elastic requesters share one
// in-order arithmetic/logic unit.
//
// Issue side: a requester is eligible once both its lhs and rhs are valid.
// The winner is picked round-robin and its operands are forwarded straight
// to the unit. The winner's index is pushed into an in-order tag FIFO.
// Return side: the FIFO head steers each unit result back to the requester
// that issued it. The arbiter adds no register stage on either path.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   ins_lhs/_valid/_ready         packed per-requester lhs channels
//   ins_rhs/_valid/_ready         packed per-requester rhs channels
//   outs_result/_valid/_ready     per-requester result channels (data replicated)
//   unit_lhs/rhs/valid/ready      operand channel to the shared unit
//   unit_result/_valid/_ready     result channel from the shared unit
//
// Build option: define SHARED_UNIT_ARBITER_FIXED_PRIO_EN to use fixed
// priority, where the lowest index wins, instead of round-robin. The grant
// lock is kept in both builds.

// Per-lane steering: issue ready and result valid for one requester.
module shared_unit_arbiter_lane #(
  parameter int IDX_W = 1,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] grant,
  input  logic [IDX_W-1:0] head,
  input  logic             fire,
  input  logic             ret_valid,
  output logic             in_ready,
  output logic             out_valid
);
  localparam logic [IDX_W-1:0] ID = IDX_W'(LANE);

  assign in_ready  = fire & (grant == ID);
  assign out_valid = ret_valid & (head == ID);
endmodule

module shared_unit_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ins_lhs,
  input  logic [NUM_REQ-1:0]            ins_lhs_valid,
  output logic [NUM_REQ-1:0]            ins_lhs_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ins_rhs,
  input  logic [NUM_REQ-1:0]            ins_rhs_valid,
  output logic [NUM_REQ-1:0]            ins_rhs_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] outs_result,
  output logic [NUM_REQ-1:0]            outs_result_valid,
  input  logic [NUM_REQ-1:0]            outs_result_ready,
  output logic [DATA_WIDTH-1:0]         unit_lhs,
  output logic [DATA_WIDTH-1:0]         unit_rhs,
  output logic                          unit_valid,
  input  logic                          unit_ready,
  input  logic [DATA_WIDTH-1:0]         unit_result,
  input  logic                          unit_result_valid,
  output logic                          unit_result_ready
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int AW    = $clog2(MAX_INFLIGHT);
  localparam int PW    = AW + 1;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lhs_a, rhs_a;
  logic [NUM_REQ-1:0] req, rdy;
  logic               any_req, fire, pop, full, empty;
  logic [IDX_W-1:0]   pick, grant, head;
  logic               lock_vld;
  logic [IDX_W-1:0]   lock_idx;
  logic [IDX_W-1:0]   tags [MAX_INFLIGHT];
  logic [PW-1:0]      wr_ptr, rd_ptr;

  assign lhs_a   = ins_lhs;
  assign rhs_a   = ins_rhs;
  assign req     = ins_lhs_valid & ins_rhs_valid;
  assign any_req = |req;

`ifdef SHARED_UNIT_ARBITER_FIXED_PRIO_EN
  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) pick = IDX_W'(i);
  end
`else
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;
  logic             found;

  // First requester at or above ptr, wrapping; one extra bit holds the
  // unwrapped sum before the modulo.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)       ptr <= '0;
    else if (fire) ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
`endif

  // A stalled offer keeps its winner, so the operands stay stable until the
  // unit accepts them.
  assign grant = lock_vld ? lock_idx : pick;

  // valid never looks at unit_ready; reset masks it immediately.
  assign unit_valid = ~rst & any_req & ~full;
  assign unit_lhs   = any_req ? lhs_a[grant] : '0;
  assign unit_rhs   = any_req ? rhs_a[grant] : '0;
  assign fire       = unit_valid & unit_ready;

  // Tag FIFO: an extra wrap bit on each pointer separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = tags[rd_ptr[AW-1:0]];

  assign unit_result_ready = ~empty & outs_result_ready[head];
  assign pop               = unit_result_valid & unit_result_ready;

  always_ff @(posedge clk)
    if (fire) tags[wr_ptr[AW-1:0]] <= grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fire) lock_vld <= 1'b0;
      else if (unit_valid) begin
        lock_vld <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

  assign outs_result   = {NUM_REQ{unit_result}};
  assign ins_lhs_ready = rdy;
  assign ins_rhs_ready = rdy;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    shared_unit_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .grant     (grant),
      .head      (head),
      .fire      (fire),
      .ret_valid (unit_result_valid & ~empty),
      .in_ready  (rdy[i]),
      .out_valid (outs_result_valid[i])
    );
  end
endmodule

// File: tb/tb_shared_unit_arbiter.sv
module tb_shared_unit_arbiter;
  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] ins_lhs = '0, ins_rhs = '0, outs_result;
  logic [N-1:0]   ins_lhs_valid = '0, ins_rhs_valid = '0;
  logic [N-1:0]   ins_lhs_ready, ins_rhs_ready;
  logic [N-1:0]   outs_result_valid, outs_result_ready = '0;
  logic [W-1:0]   unit_lhs, unit_rhs, unit_result = '0;
  logic           unit_valid, unit_ready = 1'b0, unit_result_valid = 1'b0, unit_result_ready;

  shared_unit_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_INFLIGHT(D)) dut (
    .clk(clk), .rst(rst),
    .ins_lhs(ins_lhs), .ins_lhs_valid(ins_lhs_valid), .ins_lhs_ready(ins_lhs_ready),
    .ins_rhs(ins_rhs), .ins_rhs_valid(ins_rhs_valid), .ins_rhs_ready(ins_rhs_ready),
    .outs_result(outs_result), .outs_result_valid(outs_result_valid),
    .outs_result_ready(outs_result_ready),
    .unit_lhs(unit_lhs), .unit_rhs(unit_rhs), .unit_valid(unit_valid), .unit_ready(unit_ready),
    .unit_result(unit_result), .unit_result_valid(unit_result_valid),
    .unit_result_ready(unit_result_ready)
  );

  always #5 clk = ~clk;

  // Reference: tag queue of (lane, expected xori result) in issue order,
  // plus the unit's own result queue.
  typedef struct { int lane; logic [W-1:0] data; } ent_t;
  ent_t         q[$];
  logic [W-1:0] pend[$];
  int           rr = 0;
  bit           lk = 1'b0;
  int           lk_idx = 0;
  logic [N-1:0] fired = '0;
  int           n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Check combinational outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    logic [N-1:0] req, e_ir, e_orv;
    logic [W-1:0] el, er;
    int g, j;
    bit any, found, fire, e_uv, e_urr;
    @(negedge clk);
    req = ins_lhs_valid & ins_rhs_valid;
    any = |req;
    g = 0; found = 1'b0;
    if (lk) g = lk_idx;
    else
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (!found && req[j]) begin g = j; found = 1'b1; end
      end
    e_uv = !rst && any && (q.size() < D);
    el = any ? ins_lhs[g*W +: W] : '0;
    er = any ? ins_rhs[g*W +: W] : '0;
    fire = e_uv && unit_ready;
    e_ir = '0;
    if (fire) e_ir[g] = 1'b1;
    e_urr = 1'b0;
    e_orv = '0;
    if (q.size() > 0) begin
      e_urr = outs_result_ready[q[0].lane];
      if (unit_result_valid) e_orv[q[0].lane] = 1'b1;
    end
    chk("unit_valid", unit_valid, e_uv);
    chk("unit_lhs", unit_lhs, el);
    chk("unit_rhs", unit_rhs, er);
    chk("lhs_ready", ins_lhs_ready, e_ir);
    chk("rhs_ready", ins_rhs_ready, e_ir);
    chk("res_valid", outs_result_valid, e_orv);
    chk("unit_res_ready", unit_result_ready, e_urr);
    if (e_orv != 0) chk("res_data", outs_result[q[0].lane*W +: W], q[0].data);
    @(posedge clk);
    fired = e_ir;
    if (!rst) begin
      if (e_urr && unit_result_valid) begin
        void'(q.pop_front());
        void'(pend.pop_front());
      end
      if (fire) begin
        q.push_back('{g, el ^ er});
        pend.push_back(el ^ er);
        rr = (g + 1) % N;
        lk = 1'b0;
      end else if (e_uv) begin
        lk = 1'b1;
        lk_idx = g;
      end
    end
    #1;
  endtask

  // Requesters hold valid until accepted; percentages set the activity.
  task automatic drive(input logic [N-1:0] en, input int pv, input int pu, input int prv,
                       input int po, input logic [N-1:0] omask);
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin ins_lhs_valid[i] = 1'b0; ins_rhs_valid[i] = 1'b0; end
      if (en[i] && !ins_lhs_valid[i] && $urandom_range(0, 99) < pv) begin
        ins_lhs_valid[i] = 1'b1; ins_lhs[i*W +: W] = $urandom;
      end
      if (en[i] && !ins_rhs_valid[i] && $urandom_range(0, 99) < pv) begin
        ins_rhs_valid[i] = 1'b1; ins_rhs[i*W +: W] = $urandom;
      end
      outs_result_ready[i] = omask[i] && ($urandom_range(0, 99) < po);
    end
    fired = '0;
    unit_ready = $urandom_range(0, 99) < pu;
    if (pend.size() > 0) begin
      unit_result_valid = $urandom_range(0, 99) < prv;
      unit_result = pend[0];
    end else begin
      // occasional stray result while nothing is in flight
      unit_result_valid = ($urandom_range(0, 99) < prv) && ($urandom_range(0, 7) == 0);
      unit_result = $urandom;
    end
  endtask

  task automatic run(input int n, input logic [N-1:0] en, input int pv, input int pu,
                     input int prv, input int po);
    repeat (n) begin
      drive(en, pv, pu, prv, po, '1);
      cycle();
    end
  endtask

  // Issue whatever is pending, complete half-valid lanes, return everything.
  task automatic flush();
    int t = 0;
    while ((pend.size() > 0 || (ins_lhs_valid | ins_rhs_valid) != 0) && t < 60) begin
      drive('0, 0, 100, 100, 100, '1);
      ins_rhs_valid = ins_lhs_valid | ins_rhs_valid;
      ins_lhs_valid = ins_rhs_valid;
      cycle();
      t++;
    end
    chk("flush_bound", t < 60, 1'b1);
  endtask

  initial begin
    // reset state with both lanes requesting
    ins_lhs_valid = '1; ins_rhs_valid = '1;
    unit_ready = 1'b1; outs_result_ready = '1;
    #3;
    chk("rst_unit_valid", unit_valid, 1'b0);
    chk("rst_lhs_ready", ins_lhs_ready, '0);
    chk("rst_res_valid", outs_result_valid, '0);
    chk("rst_unit_res_ready", unit_result_ready, 1'b0);
    ins_lhs_valid = '0; ins_rhs_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // lock: lane1 stalled, then lane0 (the round-robin favourite) shows up
    run(3, 2'b10, 100, 0, 0, 100);
    drive(2'b11, 100, 0, 0, 100, '1); cycle();
    drive(2'b11, 100, 100, 0, 100, '1); #1;
    chk("lock_fire", ins_lhs_ready, 2'b10);
    cycle();
    flush();

    // single requester, xori
    ins_lhs[W-1:0] = 32'h0F0F0F0F; ins_rhs[W-1:0] = 32'h00FF00FF;
    ins_lhs_valid = 2'b01; ins_rhs_valid = 2'b01;
    unit_ready = 1'b1; unit_result_valid = 1'b0; outs_result_ready = '1; fired = '0;
    #1;
    chk("single_unit_valid", unit_valid, 1'b1);
    chk("single_unit_lhs", unit_lhs, 32'h0F0F0F0F);
    cycle();
    drive('0, 0, 100, 100, 100, '1); #1;
    chk("single_res_valid", outs_result_valid, 2'b01);
    chk("single_res", outs_result[W-1:0], 32'h0FF00FF0);
    cycle();

    // contention, then fill the FIFO with no returns
    run(16, 2'b11, 100, 100, 100, 100);
    run(6, 2'b11, 100, 100, 0, 100);
    drive(2'b11, 100, 100, 0, 100, '1); #1;
    chk("full_unit_valid", unit_valid, 1'b0);
    cycle();
    drive(2'b11, 100, 100, 100, 100, '1); #1;
    chk("full_pop_no_bypass", unit_valid, 1'b0);
    cycle();
    drive(2'b11, 100, 100, 0, 100, '1); #1;
    chk("full_reopen", unit_valid, 1'b1);
    cycle();
    flush();

    // result backpressure on lane1 with lane0 ready
    drive(2'b10, 100, 100, 0, 100, '1); cycle();
    repeat (2) begin
      drive('0, 0, 0, 100, 100, 2'b01); #1;
      chk("rbp_unit_res_ready", unit_result_ready, 1'b0);
      chk("rbp_res_valid", outs_result_valid, 2'b10);
      cycle();
    end
    drive('0, 0, 0, 100, 100, 2'b11); #1;
    chk("rbp_release", unit_result_ready, 1'b1);
    cycle();
    flush();

    run(1500, 2'b11, 60, 60, 60, 70);
    flush();

    // async reset with three in flight
    run(3, 2'b11, 100, 100, 0, 100);
    drive(2'b11, 100, 100, 100, 100, '1); #1;
    rst = 1'b1; #1;
    chk("mid_rst_unit_valid", unit_valid, 1'b0);
    chk("mid_rst_unit_res_ready", unit_result_ready, 1'b0);
    chk("mid_rst_lhs_ready", ins_lhs_ready, '0);
    chk("mid_rst_rhs_ready", ins_rhs_ready, '0);
    chk("mid_rst_res_valid", outs_result_valid, '0);
    q.delete(); pend.delete(); rr = 0; lk = 1'b0; fired = '0;
    cycle();
    rst = 1'b0;
    drive(2'b11, 100, 100, 0, 100, '1); #1;
    chk("post_rst_grant", ins_lhs_ready, 2'b01);
    cycle();
    run(500, 2'b11, 70, 50, 50, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
- Lets NUM_REQ elastic requesters, each a two-operand join in the xori style, share one arithmetic/logic unit (xori, addi, etc.).
- Arbitrates issue round-robin and forwards the winner's operands to the unit.
- Records the winner's index in an in-order tag FIFO and steers each returning result to the requester that issued it.
- Sits between the per-operation channels of a resource-shared dataflow circuit and one unit instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, operand and result width.
- MAX_INFLIGHT, 4, tag FIFO depth, i.e. the maximum number of issued-but-unreturned operations (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- ins_lhs  input  NUM_REQ*DATA_WIDTH  lhs operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ins_lhs_valid  input  NUM_REQ  per-requester lhs valid.
- ins_lhs_ready  output  NUM_REQ  per-requester lhs ready.
- ins_rhs  input  NUM_REQ*DATA_WIDTH  rhs operands, same packing as ins_lhs.
- ins_rhs_valid  input  NUM_REQ  per-requester rhs valid.
- ins_rhs_ready  output  NUM_REQ  per-requester rhs ready.
- outs_result  output  NUM_REQ*DATA_WIDTH  unit_result replicated to every lane.
- outs_result_valid  output  NUM_REQ  per-requester result valid.
- outs_result_ready  input  NUM_REQ  per-requester result ready.
- unit_lhs  output  DATA_WIDTH  operand to the shared unit.
- unit_rhs  output  DATA_WIDTH  operand to the shared unit.
- unit_valid  output  1  operand pair valid.
- unit_ready  input  1  unit accepts operands.
- unit_result  input  DATA_WIDTH  unit result.
- unit_result_valid  input  1  result valid.
- unit_result_ready  output  1  result accepted.

Behaviour:
- Eligibility: req[i] = ins_lhs_valid[i] & ins_rhs_valid[i] (join semantics).
- Round-robin grant: combinational pick of the first set req, searching from register ptr upward with wrap.
- unit_valid = (|req) & !full. It never depends on unit_ready; no combinational valid←ready path.
- Grant lock:
  - If unit_valid=1 and unit_ready=0, the grant index is latched in lock_idx and lock_vld is set.
  - While lock_vld=1, the grant equals lock_idx, so unit_lhs/unit_rhs stay stable until accepted.
  - lock_vld clears on fire.
- Issue fire = unit_valid & unit_ready, same cycle as the handshake:
  - ins_lhs_ready[g] and ins_rhs_ready[g] = 1 for the granted requester g only; all other ready bits = 0.
  - g is pushed into the tag FIFO.
  - ptr <= (g+1) mod NUM_REQ.
- unit_lhs/unit_rhs = the granted lane's operands; 0 when no request is pending.
- Return path:
  - head = tag FIFO front.
  - outs_result_valid[head] = unit_result_valid & !empty; all other lanes 0.
  - unit_result_ready = !empty & outs_result_ready[head].
  - Pop on unit_result_valid & unit_result_ready.
- Ordering: results return in issue order; the unit is required to be in-order.
- Full (count=MAX_INFLIGHT): unit_valid=0. A pop in the same cycle does not enable a push until the next cycle (registered full, no bypass).
- Empty: unit_result_ready=0, all outs_result_valid=0. A unit_result_valid seen while empty is a protocol error and is ignored.
- Simultaneous push and pop, not full and not empty: count unchanged, both pointers advance.
- Pointer wrap: FIFO rd/wr pointers are log2(MAX_INFLIGHT)+1 bits; full/empty derived from MSB comparison.
- Latency:
  - Requester to unit: 0 cycles (combinational).
  - Unit result to requester: 0 cycles.
  - Arbiter adds no sequential latency.
- Reset (async, any time including mid-transfer):
  - ptr=0, lock_vld=0, FIFO empty.
  - Resulting outputs: unit_valid=0, unit_result_ready=0, all ins_*_ready=0, all outs_result_valid=0.
  - In-flight tags are discarded.

Optional Feature:
- Macro: SHARED_UNIT_ARBITER_FIXED_PRIO_EN.
- When defined:
  - Grant is fixed priority; the lowest index wins.
  - ptr is removed.
  - The lock mechanism is retained.
- When undefined: round-robin as specified above.

Test Plan:
- Single requester: NUM_REQ=2, lane0 lhs=0x0F0F0F0F, rhs=0x00FF00FF, unit=xori with 1-cycle latency, all ready=1 → unit_valid same cycle; next cycle outs_result_valid=2'b01 with lane0 result 0x0FF00FF0; lane1 never valid.
- Contention, round-robin: both lanes valid continuously, unit_ready=1 → grants alternate 0,1,0,1 for 8 issues; results return to lanes 0,1,0,1 in that order.
- Backpressure lock: unit_ready=0 for 3 cycles with lane1 granted, then lane0 becomes valid → unit_lhs stays lane1's value and lane1 fires first on unit_ready=1.
- Full: MAX_INFLIGHT=4, unit never returns results → exactly 4 fires, then unit_valid=0. One result returned with ready=1 → next cycle unit_valid=1 again.
- Result backpressure: head tag=lane1, outs_result_ready[1]=0 while outs_result_ready[0]=1 → unit_result_ready=0 and no pop until lane1 becomes ready.
- Async reset mid-burst: assert rst with 3 in flight → all valid/ready outputs 0 immediately. After release, FIFO is empty and ptr=0 (lane0 is granted first).
